// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter for the single RAM port, with a tbCTRL override.
// Define RAM_ARB_TIMEOUT_EN to abort an owner stuck in BUSY for TIMEOUT cycles.
module ram_port_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64,
    localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               tbCTRL,
    input  logic               tb_REN,
    input  logic               tb_WEN,
    input  logic [AW-1:0]      tb_addr,
    input  logic [DW-1:0]      tb_store,
    input  logic [NREQ-1:0]    req_REN,
    input  logic [NREQ-1:0]    req_WEN,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_store,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    req_err,
    output logic [DW-1:0]      req_load,
    output logic [GW-1:0]      grant_id,
    output logic               busy,
    output logic               ramREN,
    output logic               ramWEN,
    output logic [AW-1:0]      ramaddr,
    output logic [DW-1:0]      ramstore,
    input  logic [DW-1:0]      ramload,
    input  logic [1:0]         ramstate
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic [0:0]      r_state;
    logic [GW-1:0]   r_ptr;
    logic [GW-1:0]   r_owner;

    logic [NREQ-1:0] w_req;
    logic            w_any;
    logic [GW-1:0]   w_pick;
    logic [GW-1:0]   w_ptr_nxt;
    logic            w_busy;
    logic            w_own_ren;
    logic            w_own_wen;
    logic [AW-1:0]   w_own_addr;
    logic [DW-1:0]   w_own_store;
    logic            w_act;
    logic            w_live;
    logic            w_ok;
    logic            w_fail;
    logic            w_end;
    logic            w_tmo;
    logic [NREQ-1:0] w_onehot;

    assign w_req  = req_REN | req_WEN;
    assign w_busy = (r_state == S_BUSY);

    // Scan offsets high to low so the smallest offset from r_ptr wins.
    always_comb begin
        int j;
        w_any  = 1'b0;
        w_pick = r_ptr;
        j      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (w_req[j[GW-1:0]]) begin
                w_any  = 1'b1;
                w_pick = j[GW-1:0];
            end
        end
    end

    assign w_ptr_nxt = (int'(r_owner) == NREQ - 1) ? '0
                                                   : r_owner + 1'b1;

    assign w_own_ren   = req_REN[r_owner];
    assign w_own_wen   = req_WEN[r_owner];
    assign w_own_addr  = req_addr[int'(r_owner)*AW +: AW];
    assign w_own_store = req_store[int'(r_owner)*DW +: DW];
    assign w_act       = w_own_ren | w_own_wen;

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;

    // Counter sits at zero in IDLE, so it restarts on every BUSY entry.
    always_ff @(posedge CLK) begin
        if (RST || !w_busy) r_cnt <= '0;
        else                r_cnt <= r_cnt + 1'b1;
    end

    assign w_tmo = w_busy && (int'(r_cnt) >= TIMEOUT - 1);
`else
    assign w_tmo = 1'b0;
`endif

    assign w_live   = w_busy && w_act && !tbCTRL && !RST;
    assign w_ok     = w_live && (ramstate == RS_ACCESS);
    assign w_fail   = w_live && (ramstate != RS_ACCESS)
                      && ((ramstate == RS_ERROR) || w_tmo);
    assign w_end    = w_busy && (!w_act || (ramstate == RS_ACCESS)
                      || (ramstate == RS_ERROR) || w_tmo);
    assign w_onehot = NREQ'(1) << r_owner;

    assign req_ready = w_ok   ? w_onehot : '0;
    assign req_err   = w_fail ? w_onehot : '0;
    assign req_load  = ramload;
    assign grant_id  = r_owner;
    assign busy      = w_busy;

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (tbCTRL) begin
            ramREN   = tb_REN;
            ramWEN   = tb_WEN;
            ramaddr  = tb_addr;
            ramstore = tb_store;
        end else if (w_busy) begin
            ramREN   = w_own_ren && !w_own_wen;
            ramWEN   = w_own_wen;
            ramaddr  = w_own_addr;
            ramstore = w_own_store;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else if (tbCTRL) begin
            r_state <= S_IDLE;
        end else if (r_state == S_IDLE) begin
            if (w_any) begin
                r_state <= S_BUSY;
                r_owner <= w_pick;
            end
        end else if (w_end) begin
            r_state <= S_IDLE;
            r_ptr   <= w_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter against a
// transaction-level round-robin model.
module tb_ram_port_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TMO  = 4;
    localparam int GW   = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              tbCTRL;
    logic              tb_REN;
    logic              tb_WEN;
    logic [AW-1:0]     tb_addr;
    logic [DW-1:0]     tb_store;
    logic [NREQ-1:0]   req_REN;
    logic [NREQ-1:0]   req_WEN;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_store;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_err;
    logic [DW-1:0]     req_load;
    logic [GW-1:0]     grant_id;
    logic              busy;
    logic              ramREN;
    logic              ramWEN;
    logic [AW-1:0]     ramaddr;
    logic [DW-1:0]     ramstore;
    logic [DW-1:0]     ramload;
    logic [1:0]        ramstate;

    ram_port_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .tbCTRL(tbCTRL),
        .tb_REN(tb_REN), .tb_WEN(tb_WEN),
        .tb_addr(tb_addr), .tb_store(tb_store),
        .req_REN(req_REN), .req_WEN(req_WEN),
        .req_addr(req_addr), .req_store(req_store),
        .req_ready(req_ready), .req_err(req_err),
        .req_load(req_load), .grant_id(grant_id),
        .busy(busy), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: who holds the port (if anyone), where the rotation resumes.
    int m_busy, m_owner, m_ptr, m_gid, m_cnt;
    logic [NREQ-1:0] m_done;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_gid = 0; m_cnt = 0;
    endtask

    task automatic step();
        logic [NREQ-1:0] e_rdy, e_err;
        logic e_ren, e_wen;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_st;
        bit act, to;
        int pick;
        #1;
        e_rdy = '0; e_err = '0; e_ren = 0; e_wen = 0;
        e_addr = '0; e_st = '0; to = 0;
        act = (m_busy != 0) && (req_REN[m_owner] || req_WEN[m_owner]);
`ifdef RAM_ARB_TIMEOUT_EN
        to = (m_busy != 0) && (m_cnt + 1 >= TMO);
`endif
        if (tbCTRL) begin
            e_ren = tb_REN; e_wen = tb_WEN;
            e_addr = tb_addr; e_st = tb_store;
        end else if (m_busy != 0) begin
            e_wen  = req_WEN[m_owner];
            e_ren  = req_REN[m_owner] && !req_WEN[m_owner];
            e_addr = req_addr[m_owner*AW +: AW];
            e_st   = req_store[m_owner*DW +: DW];
        end
        if (!RST && !tbCTRL && act) begin
            if (ramstate == 2'd2)            e_rdy[m_owner] = 1'b1;
            else if (ramstate == 2'd3 || to) e_err[m_owner] = 1'b1;
        end
        chk("ramREN", ramREN, e_ren);
        chk("ramWEN", ramWEN, e_wen);
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_st);
        chk("req_ready", req_ready, e_rdy);
        chk("req_err", req_err, e_err);
        chk("busy", busy, m_busy != 0);
        chk("grant_id", grant_id, m_gid);
        if (e_rdy != 0) chk("req_load", req_load, ramload);
        m_done = e_rdy | e_err;
        if (RST) m_reset();
        else if (tbCTRL) m_busy = 0;
        else if (m_busy != 0) begin
            if (!act || ramstate >= 2'd2 || to) begin
                m_busy = 0;
                m_ptr = (m_owner + 1) % NREQ;
            end else m_cnt++;
        end else begin
            pick = -1;
            for (int i = NREQ - 1; i >= 0; i--)
                if (req_REN[(m_ptr + i) % NREQ] || req_WEN[(m_ptr + i) % NREQ])
                    pick = (m_ptr + i) % NREQ;
            if (pick >= 0) begin
                m_busy = 1; m_owner = pick; m_gid = pick; m_cnt = 0;
            end
        end
        @(posedge CLK);
    endtask

    task automatic clr();
        RST = 0; tbCTRL = 0; tb_REN = 0; tb_WEN = 0;
        req_REN = '0; req_WEN = '0; ramstate = 2'd0;
    endtask

    task automatic do_reset();
        @(negedge CLK); clr(); RST = 1; step();
        @(negedge CLK); RST = 0; step();
    endtask

    bit pend [NREQ];

    initial begin
        clr();
        tb_addr = '0; tb_store = '0; req_addr = '0; req_store = '0;
        ramload = '0;
        RST = 1;
        @(posedge CLK);
        m_reset();
        do_reset();
        chk("rst_busy", busy, 0);

        // ch0 read of 0x40, RAM answers two cycles later
        @(negedge CLK); req_REN[0] = 1; req_addr[0 +: AW] = 32'h40; step();
        @(negedge CLK); ramstate = 2'd1; #1 chk("t1_ren", ramREN, 1); step();
        @(negedge CLK); ramstate = 2'd2; ramload = 32'hDEADBEEF;
        #1 chk("t1_rdy", req_ready, 3'b001);
        chk("t1_load", req_load, 32'hDEADBEEF);
        step();
        @(negedge CLK); req_REN = '0; ramstate = 2'd0;
        #1 chk("t1_ren_off", ramREN, 0); step();

        // ch0 and ch1 together; ch0 keeps asking but ch1 goes next
        do_reset();
        @(negedge CLK); req_REN[0] = 1; req_REN[1] = 1; step();
        @(negedge CLK); #1 chk("t2_first", grant_id, 0);
        ramstate = 2'd2; step();
        @(negedge CLK); ramstate = 2'd0; step();
        @(negedge CLK); #1 chk("t2_second", grant_id, 1);
        ramstate = 2'd2; step();
        @(negedge CLK); req_REN[1] = 0; ramstate = 2'd0; step();
        @(negedge CLK); #1 chk("t2_third", grant_id, 0); step();
        @(negedge CLK); clr(); step();

        // ch1 write hits RAM ERROR
        do_reset();
        @(negedge CLK); req_WEN[1] = 1; req_addr[AW +: AW] = 32'h80;
        req_store[DW +: DW] = 32'h12345678; step();
        @(negedge CLK); ramstate = 2'd3;
        #1 chk("t3_err", req_err, 3'b010);
        chk("t3_store", ramstore, 32'h12345678);
        step();
        @(negedge CLK); req_WEN = '0; ramstate = 2'd0; step();

        // tbCTRL preempts an in-flight ch0 read
        @(negedge CLK); req_REN[0] = 1; step();
        @(negedge CLK); ramstate = 2'd1; step();
        @(negedge CLK); tbCTRL = 1; tb_addr = 32'hABC; tb_WEN = 1;
        ramstate = 2'd2;
        #1 chk("t4_addr", ramaddr, 32'hABC);
        step();
        @(negedge CLK); step();
        @(negedge CLK); tbCTRL = 0; tb_WEN = 0; ramstate = 2'd1; step();
        @(negedge CLK); ramstate = 2'd2; step();
        @(negedge CLK); clr(); step();

        // reset during BUSY
        @(negedge CLK); req_WEN[2] = 1; step();
        @(negedge CLK); ramstate = 2'd1; step();
        @(negedge CLK); RST = 1; ramstate = 2'd2; step();
        @(negedge CLK); RST = 0; req_WEN = '0; ramstate = 2'd0;
        #1 chk("t5_busy", busy, 0);
        chk("t5_gid", grant_id, 0);
        step();

        // RAM stuck BUSY
        @(negedge CLK); req_REN[2] = 1; step();
        for (int c = 0; c < 110; c++) begin
            @(negedge CLK); ramstate = 2'd1; step();
        end
`ifndef RAM_ARB_TIMEOUT_EN
        chk("t6_stuck", busy, 1);
`endif
        @(negedge CLK); clr(); step();
        do_reset();

        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge CLK);
            for (int i = 0; i < NREQ; i++) begin
                if (m_done[i] || (pend[i] && $urandom_range(0, 49) == 0)) begin
                    pend[i] = 0; req_REN[i] = 0; req_WEN[i] = 0;
                end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    req_REN[i] = 1'($urandom);
                    req_WEN[i] = 1'($urandom);
                    if (!req_REN[i] && !req_WEN[i]) req_REN[i] = 1;
                    req_addr[i*AW +: AW]  = $urandom;
                    req_store[i*DW +: DW] = $urandom;
                end
            end
            case ($urandom_range(0, 9))
                0:       ramstate = 2'd0;
                1, 2, 3: ramstate = 2'd2;
                4:       ramstate = 2'd3;
                default: ramstate = 2'd1;
            endcase
            ramload  = $urandom;
            tbCTRL   = ($urandom_range(0, 19) == 0);
            tb_REN   = 1'($urandom);
            tb_WEN   = 1'($urandom);
            tb_addr  = $urandom;
            tb_store = $urandom;
            RST      = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
